instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader, the write-side counterpart of the control-unit decoder. Accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake, encodes each into a 32-bit MIPS word, buffers words in a small FIFO, and streams them into instruction memory at consecutive word addresses. Sits between the testbench/program-load path and the instruction memory of the single-cycle datapath.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written after `start`.

**Ports**
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `start` input 1: one-cycle pulse; begins a load session.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready` at a rising edge.
- `in_op` input 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 ANDI, 8 ORI, 9 XORI, 10 SLTI, 11–15 illegal.
- `in_rs`, `in_rt`, `in_rd` input 5 each: register fields. `in_rd` is ignored for I-type.
- `in_imm` input 16: immediate. Ignored for R-type.
- `in_last` input 1: marks the final request of the session.
- `imem_we` output 1: write strobe.
- `imem_ready` input 1: memory accepts the write when `imem_we && imem_ready`.
- `imem_addr` output 32: byte address.
- `imem_wdata` output 32: encoded word.
- `count` output 16: words written this session.
- `done` output 1: one-cycle pulse when the session completes.
- `busy` output 1: high in RUN or FLUSH.

## Operation

**Encoding**
- R-type: {6'b000000, rs, rt, rd, 5'b0, funct}. Funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A.
- I-type: {opcode, rs, rt, imm}. Opcodes: ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, SLTI 0x0A.
- The immediate is passed through raw; there is no extension.

**FSM**
- IDLE: `start` → RUN. On entry to RUN, the address is loaded with `BASE_ADDR`, `count` is cleared to 0, and the FIFO is cleared.
- RUN: an accepted request with `in_last=1` → FLUSH.
- FLUSH: FIFO empty and no write pending → DONE.
- DONE: lasts one cycle; `done`=1; then → IDLE.
- `start` outside IDLE is ignored.

**Handshakes and counters**
- `in_ready` = (state==RUN) && FIFO not full.
- Output stage: a register holding {`imem_we`, `imem_wdata`}. It loads from the FIFO head when empty, or when its current write is accepted.
- While `imem_we=1 && imem_ready=0`, `imem_addr` and `imem_wdata` hold stable.
- Each accepted write: `imem_addr` += 4 (wraps modulo 2^32); `count` += 1 (saturates at 0xFFFF).
- A simultaneous FIFO push and pop is permitted when full or empty. When full, a pop frees the slot, but `in_ready` stays 0 that cycle because it is computed from the current occupancy.

**Reset values**
- `rst_n` low at any time, including mid-session, returns all state to its reset values immediately. Partially written memory contents are not rolled back.
- Reset values: state IDLE, FIFO empty, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `count`=0, `done`=0, `busy`=0, `in_ready`=0.

## Timing

- Accept at edge k → word enters the FIFO at edge k → `imem_we`=1 in the cycle after edge k+1, provided the FIFO was empty and the output stage was idle.
- With `imem_ready` held at 1, throughput is one word per cycle.
- `done` is asserted in the cycle after the edge that completes the last write.
- `busy` is registered and equals (state ∈ {RUN, FLUSH}).

## Configuration

- Macro: `INSTR_ENCODER_ILLEGAL_CHK_EN`.
- **Defined:** an illegal `in_op` (11–15) is still accepted by the handshake but is not written. A sticky `err` output (1 bit, reset 0, cleared on `start`) sets in the cycle after acceptance. `in_last` carried on an illegal request still ends the session.
- **Undefined:** illegal ops encode as NOP (32'h0000_0000) and are written normally. The `err` port does not exist.

## Structure

- Package `instr_enc_pkg`:
  - op enum (4-bit);
  - opcode and funct localparams (shared with the decoder);
  - FSM state typedef.
- Sub-module `instr_enc_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports: push/pop, full/empty, synchronous clear.
- The encode function lives in the package and is purely combinational.

## Test plan

1. **Single ADDI:** `start`, then ADDI rs=1 rt=2 imm=0x0005 with `in_last`, `imem_ready`=1 → one write of 0x20220005 at address 0x0; `count`=1; `done` pulses once.
2. **Mixed stream:** ADD rs=1 rt=2 rd=3; ORI rs=0 rt=4 imm=0xFFFF (`in_last`) → writes of 0x00221820 @0x0 and 0x3404FFFF @0x4.
3. **Backpressure:** `imem_ready`=0 while 6 requests are offered with DEPTH=4 → `in_ready` drops after 4 FIFO entries plus 1 in the output stage; address and data are held stable. Releasing `imem_ready` → all 6 words are written in order at 0x0–0x14.
4. **Reset mid-session:** `rst_n` low after 2 of 5 writes → all outputs return to their reset values. A new `start` restarts at `BASE_ADDR` with `count`=0.
5. **Illegal op:** op=12 → with the macro, nothing is written and `err`=1; without the macro, 0x00000000 is written.
6. **Ignored start:** `start` asserted during RUN → no effect; address and `count` continue.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared definitions for the MIPS instruction encoder.
//   - op_e        : symbolic operation codes accepted on in_op
//   - OPC_* / FUNCT_* : MIPS opcode and funct fields (shared with the decoder)
//   - state_e     : load-session FSM states
//   - encode()    : purely combinational symbolic-to-binary encoder
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_ADDI = 4'd6,
    OP_ANDI = 4'd7,
    OP_ORI  = 4'd8,
    OP_XORI = 4'd9,
    OP_SLTI = 4'd10
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd10);
  endfunction

  // Illegal ops fall through to 32'h0 (a MIPS NOP).
  function automatic logic [31:0] encode(input logic [3:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm);
    logic [31:0] word;
    word = 32'h0;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_OR};
      OP_XOR:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_XOR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SLT};
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      OP_ANDI: word = {OPC_ANDI, rs, rt, imm};
      OP_ORI:  word = {OPC_ORI,  rs, rt, imm};
      OP_XORI: word = {OPC_XORI, rs, rt, imm};
      OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: small synchronous FIFO with a synchronous clear.
// Ports: push/wdata (write side), pop/rdata (read side, rdata is the head,
// valid while !empty), full/empty flags, clr empties the FIFO.
// A push while full is taken only when a pop happens in the same cycle.
module instr_enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic MIPS requests into 32-bit words, buffers
// them in a FIFO and streams them into instruction memory at consecutive
// word addresses starting at BASE_ADDR.
// Ports: start (session pulse), in_* (request + valid/ready handshake),
// imem_* (memory write port with ready backpressure), count (words written),
// done (session-complete pulse), busy (RUN or FLUSH), err (optional).
// Optional feature macro INSTR_ENCODER_ILLEGAL_CHK_EN: illegal ops are
// dropped instead of written as NOP, and a sticky err output is added.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | accepting requests until one with in_last
// ST_FLUSH | draining FIFO and output stage into memory
// ST_DONE  | one-cycle done pulse, then back to idle
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] count,
  output logic        done,
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
  output logic        err,
`endif
  output logic        busy
);

  state_e      state;
  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_clr;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic [31:0] enc_word;
  logic        out_load;
  logic        write_ok;

  assign in_ready = (state == ST_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign enc_word = encode(in_op, in_rs, in_rt, in_rd, in_imm);

`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
  logic legal;
  assign legal     = op_is_legal(in_op);
  assign fifo_push = accept && legal;
`else
  assign fifo_push = accept;
`endif

  // The output stage reloads when idle or when its write is being taken.
  assign write_ok = imem_we && imem_ready;
  assign out_load = !imem_we || imem_ready;
  assign fifo_pop = out_load && !fifo_empty;
  assign fifo_clr = (state == ST_IDLE) && start;

  instr_enc_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      count      <= 16'h0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (out_load) begin
        imem_we <= !fifo_empty;
        if (!fifo_empty) imem_wdata <= fifo_rdata;
      end

      if (write_ok) begin
        imem_addr <= imem_addr + 32'd4;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            imem_addr <= BASE_ADDR;
            count     <= 16'h0;
          end
        end
        ST_RUN: begin
          if (accept && in_last) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Leave as the final write completes so done lands one cycle after it.
          if (fifo_empty && out_load) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (fifo_clr) begin
      err <= 1'b0;
    end else if (accept && !legal) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of encoded vectors plus
// hand-written sessions for backpressure, reset, illegal op and stray start.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        in_last;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] count;
  logic        done;
  logic        busy;
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
  logic        err;
`endif

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
    .err        (err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  logic [31:0] exp_addr;
  vec_t        vt[13];
  vec_t        bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted memory write is checked against the queue head.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && imem_we && imem_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got 0x%08h @0x%08h, expected none", imem_wdata, imem_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    exp_addr = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last);
    bit ok;
    ok = 1'b0;
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_imm = v.imm;
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
      in_last = 1'b0;
      return;
    end
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
    if (v.op <= 4'd10) begin
      exp_q.push_back('{addr: exp_addr, data: v.word});
      exp_addr += 32'd4;
    end
`else
    exp_q.push_back('{addr: exp_addr, data: v.word});
    exp_addr += 32'd4;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] exp_count);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_pulse", done, 1);
    check("count", count, exp_count);
    check("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
  endtask

  initial begin
    // op, rs, rt, rd, imm, expected word (hand-encoded)
    vt[0]  = '{4'd6,  5'd1,  5'd2,  5'd0,  16'h0005, 32'h2022_0005}; // ADDI
    vt[1]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h1234, 32'h0022_1820}; // ADD, imm ignored
    vt[2]  = '{4'd8,  5'd0,  5'd4,  5'd0,  16'hFFFF, 32'h3404_FFFF}; // ORI
    vt[3]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 32'h0085_3022}; // SUB
    vt[4]  = '{4'd2,  5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FF_F824}; // AND
    vt[5]  = '{4'd3,  5'd2,  5'd3,  5'd1,  16'h0000, 32'h0043_0825}; // OR
    vt[6]  = '{4'd4,  5'd7,  5'd8,  5'd9,  16'h0000, 32'h00E8_4826}; // XOR
    vt[7]  = '{4'd5,  5'd1,  5'd1,  5'd1,  16'h0000, 32'h0021_082A}; // SLT
    vt[8]  = '{4'd7,  5'd3,  5'd4,  5'd0,  16'h00FF, 32'h3064_00FF}; // ANDI
    vt[9]  = '{4'd9,  5'd0,  5'd1,  5'd0,  16'h8000, 32'h3801_8000}; // XORI, no sign ext
    vt[10] = '{4'd10, 5'd5,  5'd6,  5'd0,  16'hFFFF, 32'h28A6_FFFF}; // SLTI
    vt[11] = '{4'd6,  5'd0,  5'd0,  5'd31, 16'h0000, 32'h2000_0000}; // ADDI, rd ignored
    vt[12] = '{4'd8,  5'd31, 5'd0,  5'd0,  16'h0001, 32'h37E0_0001}; // ORI rs=31
    bad    = '{4'd12, 5'd1,  5'd2,  5'd3,  16'h00AA, 32'h0000_0000}; // illegal -> NOP

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    imem_ready = 1'b1; exp_addr = 32'h0;

    #23;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ADDI with first-word latency check.
    pulse_start();
    check("busy_in_run", busy, 1);
    send(vt[0], 1'b1);
    check("latency_we_low", imem_we, 0);
    @(posedge clk); #1;
    check("latency_we_high", imem_we, 1);
    wait_done(16'd1);

    // Table stream at full throughput.
    pulse_start();
    for (int i = 0; i < 13; i++) send(vt[i], (i == 12));
    wait_done(16'd13);

    // Backpressure: 5 accepted, 6th stalls, output held.
    imem_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) send(vt[i], 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_we", imem_we, 1);
      check("bp_addr", imem_addr, 32'h0);
      check("bp_wdata", imem_wdata, vt[0].word);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send(vt[5], 1'b1);
    wait_done(16'd6);

    // Reset after 2 of 5 writes, then a clean restart.
    imem_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) send(vt[i+6], (i == 4));
    @(posedge clk); #1;
    imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    check("mid_count", count, 16'd2);
    check("mid_addr", imem_addr, 32'h8);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    pulse_start();
    check("restart_count", count, 0);
    send(vt[1], 1'b1);
    wait_done(16'd1);

    // Illegal op.
    pulse_start();
    send(bad, 1'b1);
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
    wait_done(16'd0);
    check("err_set", err, 1);
`else
    wait_done(16'd1);
`endif

    // Start during RUN is ignored.
    pulse_start();
`ifdef INSTR_ENCODER_ILLEGAL_CHK_EN
    check("err_cleared", err, 0);
`endif
    send(vt[2], 1'b0);
    start = 1'b1;
    send(vt[3], 1'b0);
    start = 1'b0;
    check("ign_busy", busy, 1);
    send(vt[4], 1'b1);
    wait_done(16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
